// File: rtl/pipeline_hazard_controller_if.sv
// Pipeline control bus between the hazard controller and the datapath stages.
// The controller attaches to the slave modport; the datapath (or a bench) uses master.
interface pipeline_hazard_controller_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic       ex_mem_read;
  logic [4:0] ex_rd;
  logic       ex_branch_taken;
  // RAM handshake: mem_req marks an access in MEM this cycle, mem_ready completes it in the
  // same cycle; mem_req with mem_ready low is a wait cycle that freezes every stage.
  logic       mem_req;
  logic       mem_ready;
  logic       halt_req;
  logic       resume;

  logic       pc_wren;
  logic       if_id_wren;
  logic       if_id_flush;
  logic       id_ex_wren;
  logic       id_ex_flush;
  logic       ex_mem_wren;
  logic       mem_wb_wren;
  logic       halted;
  logic       mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_mem_read, ex_rd,
           ex_branch_taken, mem_req, mem_ready, halt_req, resume,
    input  pc_wren, if_id_wren, if_id_flush, id_ex_wren, id_ex_flush,
           ex_mem_wren, mem_wb_wren, halted, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_mem_read, ex_rd,
           ex_branch_taken, mem_req, mem_ready, halt_req, resume,
    output pc_wren, if_id_wren, if_id_flush, id_ex_wren, id_ex_flush,
           ex_mem_wren, mem_wb_wren, halted, mem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use, branch flush, RAM waits,
// drain/halt and RAM-timeout trap. Define PIPE_CTRL_PERF_EN to add stall/flush counters.
module pipeline_hazard_controller #(
  parameter int MEM_TIMEOUT  = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  pipeline_hazard_controller_if.slave bus,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
`endif
  output logic [2:0] state_dbg
);
  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_MEM_WAIT = 3'd1,
    S_DRAIN    = 3'd2,
    S_HALTED   = 3'd3,
    S_ERROR    = 3'd4
  } state_t;

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 2);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [WAIT_W-1:0]  TIMEOUT_V  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  state_t state, state_n;
  logic [WAIT_W-1:0]  wait_cnt, wait_cnt_n;
  logic [DRAIN_W-1:0] drain_cnt, drain_cnt_n;
  logic ret_drain, ret_drain_n;
  logic halt_pend, halt_pend_n;
  logic mem_stall, load_use, draining;
  logic pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w, halted_o, timeout_o;

  assign mem_stall = bus.mem_req & ~bus.mem_ready;
  assign load_use  = bus.ex_mem_read & (bus.ex_rd != 5'd0) &
                     ((bus.id_rs1_used & (bus.id_rs1 == bus.ex_rd)) |
                      (bus.id_rs2_used & (bus.id_rs2 == bus.ex_rd)));
  // A RAM wait entered from DRAIN keeps draining semantics for its completing cycle.
  assign draining  = (state == S_DRAIN) | ((state == S_MEM_WAIT) & ret_drain);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_RUN;
      wait_cnt  <= '0;
      drain_cnt <= '0;
      ret_drain <= 1'b0;
      halt_pend <= 1'b0;
    end else begin
      state     <= state_n;
      wait_cnt  <= wait_cnt_n;
      drain_cnt <= drain_cnt_n;
      ret_drain <= ret_drain_n;
      halt_pend <= halt_pend_n;
    end
  end

  always_comb begin
    state_n     = state;
    wait_cnt_n  = wait_cnt;
    drain_cnt_n = drain_cnt;
    ret_drain_n = ret_drain;
    halt_pend_n = halt_pend;
    case (state)
      S_RUN, S_MEM_WAIT, S_DRAIN: begin
        if (mem_stall) begin
          wait_cnt_n = wait_cnt + 1'b1;
          if (state != S_MEM_WAIT) ret_drain_n = (state == S_DRAIN);
          if (!draining && bus.halt_req) halt_pend_n = 1'b1;
          if ((MEM_TIMEOUT != 0) && (wait_cnt_n == TIMEOUT_V)) state_n = S_ERROR;
          else state_n = S_MEM_WAIT;
        end else begin
          wait_cnt_n = '0;
          if (draining) begin
            if (drain_cnt == DRAIN_LAST) begin
              state_n     = S_HALTED;
              drain_cnt_n = '0;
            end else begin
              state_n     = S_DRAIN;
              drain_cnt_n = drain_cnt + 1'b1;
            end
          end else if (bus.halt_req | halt_pend) begin
            state_n     = S_DRAIN;
            drain_cnt_n = '0;
            halt_pend_n = 1'b0;
          end else begin
            state_n = S_RUN;
          end
        end
      end
      S_HALTED: if (bus.resume) state_n = S_RUN;
      default:  state_n = S_ERROR;
    endcase
  end

  always_comb begin
    pc_w      = 1'b0;
    ifid_w    = 1'b0;
    ifid_f    = 1'b0;
    idex_w    = 1'b0;
    idex_f    = 1'b0;
    exmem_w   = 1'b0;
    memwb_w   = 1'b0;
    halted_o  = 1'b0;
    timeout_o = 1'b0;
    if (!reset_n) begin
      {pc_w, ifid_w, idex_w, exmem_w, memwb_w} = 5'b11111;
    end else begin
      case (state)
        S_HALTED: halted_o  = 1'b1;
        S_ERROR:  timeout_o = 1'b1;
        default: begin
          if (!mem_stall) begin
            {ifid_w, idex_w, exmem_w, memwb_w} = 4'b1111;
            if (bus.ex_branch_taken) begin
              pc_w   = 1'b1;
              ifid_f = 1'b1;
              idex_f = 1'b1;
            end else if (load_use) begin
              ifid_w = 1'b0;
              idex_f = 1'b1;
            end else if (draining) begin
              ifid_f = 1'b1;
            end else begin
              pc_w = 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.pc_wren     = pc_w;
  assign bus.if_id_wren  = ifid_w;
  assign bus.if_id_flush = ifid_f;
  assign bus.id_ex_wren  = idex_w;
  assign bus.id_ex_flush = idex_f;
  assign bus.ex_mem_wren = exmem_w;
  assign bus.mem_wb_wren = memwb_w;
  assign bus.halted      = halted_o;
  assign bus.mem_timeout = timeout_o;

`ifdef PIPE_CTRL_PERF_EN
  logic counting;
  assign counting = (state == S_RUN) | (state == S_MEM_WAIT) | (state == S_DRAIN);

  // A load-use overridden by a taken branch is a flush, not a stall.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else if (counting) begin
      if (mem_stall | (load_use & ~bus.ex_branch_taken)) stall_cycles <= stall_cycles + 32'd1;
      if (~mem_stall & bus.ex_branch_taken) flush_events <= flush_events + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed scenarios plus random cycles, each cycle's
// expected control vector queued by a reference model and popped by an independent monitor.
`timescale 1ns/1ps
module tb_pipeline_hazard_controller;
  localparam int MEM_TIMEOUT  = 16;
  localparam int DRAIN_CYCLES = 4;
  localparam int P_RUN = 0, P_WAIT = 1, P_DRAIN = 2, P_HALT = 3, P_ERR = 4;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1u;
    logic       rs2u;
    logic       mrd;
    logic [4:0] rd;
    logic       br;
    logic       mreq;
    logic       mrdy;
    logic       halt;
    logic       res;
  } stim_t;

  logic clk = 1'b0;
  logic reset_n;
  logic [2:0] state_dbg;
  always #5 clk = ~clk;

  pipeline_hazard_controller_if bus_if();
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
`endif

  pipeline_hazard_controller #(.MEM_TIMEOUT(MEM_TIMEOUT), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus_if),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cycles(stall_cycles),
    .flush_events(flush_events),
`endif
    .state_dbg(state_dbg)
  );

  // Reference model state (phase names follow the behavioural description).
  int ph, waited, drained, cyc;
  bit back_to_drain, pend;
  logic [31:0] m_stalls, m_flushes;
  logic [8:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    s.mrdy  = 1'b1;
    return s;
  endfunction

  function automatic stim_t rst();
    stim_t s;
    s = '0;
    return s;
  endfunction

  // Vector order: {pc, if_id_w, if_id_f, id_ex_w, id_ex_f, ex_mem_w, mem_wb_w, halted, timeout}
  task automatic drive(input stim_t s);
    logic [8:0] e;
    bit stall, lu, dr;
    reset_n                = s.rst_n;
    bus_if.id_rs1          = s.rs1;
    bus_if.id_rs2          = s.rs2;
    bus_if.id_rs1_used     = s.rs1u;
    bus_if.id_rs2_used     = s.rs2u;
    bus_if.ex_mem_read     = s.mrd;
    bus_if.ex_rd           = s.rd;
    bus_if.ex_branch_taken = s.br;
    bus_if.mem_req         = s.mreq;
    bus_if.mem_ready       = s.mrdy;
    bus_if.halt_req        = s.halt;
    bus_if.resume          = s.res;
    stall = s.mreq && !s.mrdy;
    lu = s.mrd && (s.rd != 5'd0) &&
         ((s.rs1u && (s.rs1 == s.rd)) || (s.rs2u && (s.rs2 == s.rd)));
    dr = (ph == P_DRAIN) || ((ph == P_WAIT) && back_to_drain);
    e = 9'b0;
    if (!s.rst_n) begin
      e = 9'b110101100;
      ph = P_RUN; waited = 0; drained = 0; back_to_drain = 0; pend = 0;
      m_stalls = 0; m_flushes = 0;
    end else if (ph == P_ERR) begin
      e = 9'b000000001;
    end else if (ph == P_HALT) begin
      e = 9'b000000010;
      if (s.res) ph = P_RUN;
    end else if (stall) begin
      m_stalls = m_stalls + 1;
      if (ph != P_WAIT) back_to_drain = (ph == P_DRAIN);
      if (s.halt && !dr) pend = 1;
      waited++;
      ph = (MEM_TIMEOUT > 0 && waited >= MEM_TIMEOUT) ? P_ERR : P_WAIT;
    end else begin
      if (s.br) begin
        e = 9'b111111100;
        m_flushes = m_flushes + 1;
      end else if (lu) begin
        e = 9'b000111100;
        m_stalls = m_stalls + 1;
      end else if (dr) e = 9'b011101100;
      else e = 9'b110101100;
      waited = 0;
      if (dr) begin
        drained++;
        ph = (drained >= DRAIN_CYCLES) ? P_HALT : P_DRAIN;
      end else if (s.halt || pend) begin
        ph = P_DRAIN; drained = 0; pend = 0;
      end else ph = P_RUN;
    end
    exp_q.push_back(e);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_n(input stim_t s, input int n);
    for (int i = 0; i < n; i++) drive(s);
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic check_perf(input string name, input logic [31:0] st, input logic [31:0] fl);
    n_checks++;
    if (stall_cycles === st && flush_events === fl) n_pass++;
    else $display("FAIL perf_%s stall_cycles=%0d flush_events=%0d required %0d/%0d",
                  name, stall_cycles, flush_events, st, fl);
  endtask
`endif

  // Monitor: one control vector per cycle, sampled mid-cycle.
  initial begin
    logic [8:0] e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus_if.pc_wren, bus_if.if_id_wren, bus_if.if_id_flush, bus_if.id_ex_wren,
             bus_if.id_ex_flush, bus_if.ex_mem_wren, bus_if.mem_wb_wren, bus_if.halted,
             bus_if.mem_timeout};
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL ctrl_vec t=%0t actual=%b required=%b state=%0d", $time, a, e, state_dbg);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    cyc = 0; ph = P_RUN; waited = 0; drained = 0; back_to_drain = 0; pend = 0;
    m_stalls = 0; m_flushes = 0;
    reset_n = 1'b0;
    {bus_if.id_rs1, bus_if.id_rs2, bus_if.id_rs1_used, bus_if.id_rs2_used, bus_if.ex_mem_read,
     bus_if.ex_rd, bus_if.ex_branch_taken, bus_if.mem_req, bus_if.mem_ready, bus_if.halt_req,
     bus_if.resume} = '0;
    @(posedge clk);
    #1;
    drive_n(rst(), 2);

    // Load-use on rs1, then the same with rd=x0.
    drive(idle());
    s = idle(); s.mrd = 1; s.rd = 5'd5; s.rs1 = 5'd5; s.rs1u = 1;
    drive(s);
    s.rd = 5'd0;
    drive(s);
    // Three RAM wait cycles then completion.
    s = idle(); s.mreq = 1; s.mrdy = 0;
    drive_n(s, 3);
    s.mrdy = 1;
    drive(s);
    drive(idle());
    // Branch together with load-use on rs2.
    s = idle(); s.mrd = 1; s.rd = 5'd7; s.rs2 = 5'd7; s.rs2u = 1; s.br = 1;
    drive(s);
    drive(idle());
`ifdef PIPE_CTRL_PERF_EN
    check_perf("scn124", 32'd4, 32'd1);
`endif

    // RAM timeout, sticky with mem_ready high.
    drive(rst());
    s = idle(); s.mreq = 1; s.mrdy = 0;
    drive_n(s, MEM_TIMEOUT + 3);
    s.mrdy = 1; s.br = 1;
    drive_n(s, 3);
    drive(rst());
`ifdef PIPE_CTRL_PERF_EN
    check_perf("after_reset", 32'd0, 32'd0);
`endif

    // Halt with a two-cycle RAM wait inside DRAIN, then resume.
    drive(idle());
    s = idle(); s.halt = 1;
    drive(s);
    drive_n(idle(), 2);
    s = idle(); s.mreq = 1; s.mrdy = 0;
    drive_n(s, 2);
    drive_n(idle(), 2);
    s = idle(); s.halt = 1;
    drive_n(s, 2);
    s = idle(); s.res = 1;
    drive(s);
    drive_n(idle(), 2);
    // Halt requested during a RAM wait, plus resume ignored outside HALTED.
    s = idle(); s.mreq = 1; s.mrdy = 0; s.halt = 1;
    drive(s);
    s.halt = 0; s.res = 1;
    drive(s);
    drive_n(idle(), DRAIN_CYCLES + 2);
    s = idle(); s.res = 1;
    drive(s);
    drive(idle());

    // Random traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      s = idle();
      if ($urandom_range(0, 59) == 0) s.rst_n = 0;
      s.rs1  = 5'($urandom_range(0, 3));
      s.rs2  = 5'($urandom_range(0, 3));
      s.rd   = 5'($urandom_range(0, 3));
      s.rs1u = 1'($urandom_range(0, 1));
      s.rs2u = 1'($urandom_range(0, 1));
      s.mrd  = ($urandom_range(0, 2) == 0);
      s.br   = ($urandom_range(0, 5) == 0);
      s.mreq = ($urandom_range(0, 2) == 0);
      s.mrdy = ($urandom_range(0, 3) != 0);
      s.halt = ($urandom_range(0, 19) == 0);
      s.res  = ($urandom_range(0, 5) == 0);
      drive(s);
`ifdef PIPE_CTRL_PERF_EN
      if (i % 50 == 49) check_perf("random", m_stalls, m_flushes);
`endif
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain left=%0d required=0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
